// File: rtl/cache_refill_arbiter_pkg.sv
// Shared definitions for the cache refill arbiter: FSM encoding and memory word geometry.
package cache_refill_arbiter_pkg;

  localparam int STATE_W        = 3;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_OFF_W     = 2;

  localparam logic [STATE_W-1:0] S_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] S_D_WB   = 3'd1;
  localparam logic [STATE_W-1:0] S_D_FILL = 3'd2;
  localparam logic [STATE_W-1:0] S_I_FILL = 3'd3;
  localparam logic [STATE_W-1:0] S_D_DONE = 3'd4;
  localparam logic [STATE_W-1:0] S_I_DONE = 3'd5;

endpackage

// File: rtl/cache_refill_arbiter.sv
// Shares one word-wide memory port between ICache and DCache misses, sequencing
// dirty write-back then line refill one word per MemAck; drives pipeline stall requests.
module cache_refill_arbiter
  import cache_refill_arbiter_pkg::*;
#(
  parameter  int LINE_WORDS = 4,
  parameter  int ADDR_W     = 32,
  parameter  int DATA_W     = 32,
  localparam int IDX_W      = $clog2(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              IMissReq,
  input  logic [ADDR_W-1:0] IMissAddr,
  input  logic              DMissReq,
  input  logic [ADDR_W-1:0] DMissAddr,
  input  logic              DDirty,
  input  logic [ADDR_W-1:0] DVictimAddr,
  input  logic [DATA_W-1:0] DVictimData,
  output logic              MemReq,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWData,
  input  logic [DATA_W-1:0] MemRData,
  input  logic              MemAck,
  output logic [IDX_W-1:0]  WordIdx,
  output logic              IRefillWe,
  output logic              DRefillWe,
  output logic              IRefillDone,
  output logic              DRefillDone,
  output logic              ICacheMiss,
  output logic              DCacheMiss
);

  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_WORDS * BYTES_PER_WORD - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(LINE_WORDS - 1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  i_base_q, i_base_d;
  logic [ADDR_W-1:0]  d_base_q, d_base_d;
  logic [ADDR_W-1:0]  v_base_q, v_base_d;

  logic              in_wb, in_dfill, in_ifill;
  logic              last_word;
  logic [ADDR_W-1:0] cur_base;
  logic [ADDR_W-1:0] word_off;

  // Refill data goes straight into the cache arrays; the arbiter only sequences it.
  logic rdata_unused;
  assign rdata_unused = ^MemRData;

  assign in_wb     = (state_q == S_D_WB);
  assign in_dfill  = (state_q == S_D_FILL);
  assign in_ifill  = (state_q == S_I_FILL);
  assign last_word = (cnt_q == LAST_IDX);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    i_base_d = i_base_q;
    d_base_d = d_base_q;
    v_base_d = v_base_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        // DCache wins ties: its miss belongs to the older instruction.
        if (DMissReq) begin
          d_base_d = DMissAddr & ~OFF_MASK;
          v_base_d = DVictimAddr & ~OFF_MASK;
          state_d  = DDirty ? S_D_WB : S_D_FILL;
        end else if (IMissReq) begin
          i_base_d = IMissAddr & ~OFF_MASK;
          state_d  = S_I_FILL;
        end
      end
      S_D_WB: begin
        if (MemAck) begin
          cnt_d = cnt_q + IDX_W'(1);
          if (last_word) state_d = S_D_FILL;
        end
      end
      S_D_FILL: begin
        if (MemAck) begin
          cnt_d = cnt_q + IDX_W'(1);
          if (last_word) state_d = S_D_DONE;
        end
      end
      S_I_FILL: begin
        if (MemAck) begin
          cnt_d = cnt_q + IDX_W'(1);
          if (last_word) state_d = S_I_DONE;
        end
      end
      S_D_DONE: state_d = S_IDLE;
      S_I_DONE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      i_base_q <= '0;
      d_base_q <= '0;
      v_base_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      i_base_q <= i_base_d;
      d_base_q <= d_base_d;
      v_base_q <= v_base_d;
    end
  end

  always_comb begin
    cur_base = '0;
    if (in_wb)         cur_base = v_base_q;
    else if (in_dfill) cur_base = d_base_q;
    else if (in_ifill) cur_base = i_base_q;
  end

  // Word offset is OR-ed into an aligned base, so the last word never carries.
  assign word_off = ADDR_W'({cnt_q, {WORD_OFF_W{1'b0}}});

  assign MemReq      = in_wb | in_dfill | in_ifill;
  assign MemWe       = in_wb;
  assign MemAddr     = MemReq ? (cur_base | word_off) : '0;
  assign MemWData    = in_wb ? DVictimData : '0;
  assign WordIdx     = cnt_q;
  assign IRefillWe   = in_ifill & MemAck;
  assign DRefillWe   = in_dfill & MemAck;
  assign IRefillDone = (state_q == S_I_DONE);
  assign DRefillDone = (state_q == S_D_DONE);

  // Stalls release in the Done cycle so the pipeline resumes right after the last write.
  assign ICacheMiss  = IMissReq & ~IRefillDone;
  assign DCacheMiss  = DMissReq & ~DRefillDone;

endmodule
